// File: rtl/seg_scan_ctrl.sv
// Multiplexed 7-segment scan controller: drives one shared hex decoder and active-low anodes,
// with a dead gap between digits and tear-free frame-boundary commits of new display values.
module seg_scan_ctrl #(
   parameter int NUM_DIGITS  = 4,
   parameter int REFRESH_DIV = 50000,
   parameter int DEAD_CYC    = 500
) (
   input  logic                    clk,
   input  logic                    rst_n,
   input  logic                    enable,
   input  logic                    load_valid,
   output logic                    load_ready,
   input  logic [4*NUM_DIGITS-1:0] value_in,
   input  logic [NUM_DIGITS-1:0]   blank_mask,
   output logic [3:0]              dec_nibble,
   output logic [NUM_DIGITS-1:0]   an_n,
   output logic                    frame_tick
);

   localparam int CNT_MAX = (REFRESH_DIV > DEAD_CYC) ? REFRESH_DIV : DEAD_CYC;
   localparam int CNT_W   = $clog2(CNT_MAX) + 1;
   localparam int IDX_W   = $clog2(NUM_DIGITS);

   localparam logic [CNT_W-1:0] DEAD_LAST = CNT_W'(DEAD_CYC - 1);
   localparam logic [CNT_W-1:0] REF_LAST  = CNT_W'(REFRESH_DIV - 1);
   localparam logic [IDX_W-1:0] IDX_LAST  = IDX_W'(NUM_DIGITS - 1);

   typedef enum logic {DEAD, DRIVE} state_t;

   state_t                  state, state_nx;
   logic [CNT_W-1:0]        cnt, cnt_nx;
   logic [IDX_W-1:0]        idx, idx_nx;
   logic [4*NUM_DIGITS-1:0] disp_reg, shadow;
   logic                    pending;
   logic [NUM_DIGITS-1:0]   an_nx;
   logic                    frame_nx;
   logic                    leave_drive;
   logic                    commit;
   logic                    accept;

   // Next-state lookahead so every output can be registered yet track the current state.
   always_comb begin
      state_nx    = state;
      cnt_nx      = cnt + CNT_W'(1);
      idx_nx      = idx;
      leave_drive = 1'b0;
      if (state == DEAD) begin
         if (cnt == DEAD_LAST) begin
            state_nx = DRIVE;
            cnt_nx   = '0;
         end
      end else begin
         if (cnt == REF_LAST) begin
            leave_drive = 1'b1;
            state_nx    = DEAD;
            cnt_nx      = '0;
            idx_nx      = (idx == IDX_LAST) ? '0 : idx + IDX_W'(1);
         end
      end
      an_nx = '1;
      if (state_nx == DRIVE && enable && !blank_mask[idx_nx])
         an_nx[idx_nx] = 1'b0;
      frame_nx = (state_nx == DRIVE) && (cnt_nx == REF_LAST) && (idx_nx == IDX_LAST);
   end

   // frame_tick is high exactly during the frame-end cycle, so it doubles as the commit strobe.
   assign commit     = frame_tick && pending;
   assign accept     = load_valid && !pending;
   assign load_ready = !pending;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state      <= DEAD;
         cnt        <= '0;
         idx        <= '0;
         an_n       <= '1;
         frame_tick <= 1'b0;
         dec_nibble <= '0;
         disp_reg   <= '0;
         shadow     <= '0;
         pending    <= 1'b0;
      end else begin
         state      <= state_nx;
         cnt        <= cnt_nx;
         idx        <= idx_nx;
         an_n       <= an_nx;
         frame_tick <= frame_nx;
         // Digit 0 of a freshly committed frame must already show the new value.
         if (leave_drive)
            dec_nibble <= commit ? shadow[4*idx_nx +: 4] : disp_reg[4*idx_nx +: 4];
         if (commit) begin
            disp_reg <= shadow;
            pending  <= 1'b0;
         end else if (accept) begin
            shadow  <= value_in;
            pending <= 1'b1;
         end
      end
   end

endmodule

// File: tb/tb_seg_scan_ctrl.sv
// Randomized self-checking bench for seg_scan_ctrl against a frame-arithmetic reference model.
module tb_seg_scan_ctrl;

   localparam int ND   = 4;
   localparam int RDIV = 4;
   localparam int DCYC = 1;
   localparam int SLOT = DCYC + RDIV;
   localparam int FRM  = ND * SLOT;

   logic        clk = 1'b0;
   logic        rst_n;
   logic        enable;
   logic        load_valid;
   logic        load_ready;
   logic [15:0] value_in;
   logic [3:0]  blank_mask;
   logic [3:0]  dec_nibble;
   logic [3:0]  an_n;
   logic        frame_tick;

   seg_scan_ctrl #(.NUM_DIGITS(ND), .REFRESH_DIV(RDIV), .DEAD_CYC(DCYC)) dut (
      .clk(clk), .rst_n(rst_n), .enable(enable), .load_valid(load_valid),
      .load_ready(load_ready), .value_in(value_in), .blank_mask(blank_mask),
      .dec_nibble(dec_nibble), .an_n(an_n), .frame_tick(frame_tick)
   );

   always #5 clk = ~clk;

   int passed = 0;
   int total  = 0;

   // Reference model: position in frame is pure cycle arithmetic since reset release.
   int          t;
   logic [15:0] m_disp, m_shadow;
   bit          m_pend;
   bit          prev_en;
   logic [3:0]  prev_blank;
   logic [3:0]  prev_dec;

   task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
      total++;
      if (got === exp) passed++;
      else $display("FAIL %s t=%0d got=%h exp=%h", tag, t, got, exp);
   endtask

   task automatic model_reset();
      t = 0; m_disp = '0; m_shadow = '0; m_pend = 0;
      prev_en = 0; prev_blank = '1; prev_dec = '0;
   endtask

   task automatic finish_cycle();
      int pos, slot;
      bit drv, cmt, acc;
      logic [3:0] exp_an;
      pos  = t % FRM;
      slot = pos / SLOT;
      drv  = (pos % SLOT) >= DCYC;
      exp_an = 4'hF;
      if (drv && prev_en && !prev_blank[slot]) exp_an[slot] = 1'b0;
      check_val("an_n", an_n, exp_an);
      check_val("dec_nibble", dec_nibble, m_disp[4*slot +: 4]);
      check_val("frame_tick", frame_tick, pos == FRM-1);
      check_val("load_ready", load_ready, !m_pend);
      check_val("one_anode", $countones(~an_n) <= 1, 1);
      if (an_n != 4'hF) check_val("dec_stable", dec_nibble, prev_dec);
      cmt = (pos == FRM-1) && m_pend;
      acc = load_valid && !m_pend;
      if (cmt) begin
         m_disp = m_shadow; m_pend = 0;
      end else if (acc) begin
         m_shadow = value_in; m_pend = 1;
      end
      prev_en = enable; prev_blank = blank_mask; prev_dec = dec_nibble;
      t++;
   endtask

   task automatic step(input bit v, input logic [15:0] val, input bit en, input logic [3:0] bl);
      load_valid = v; value_in = val; enable = en; blank_mask = bl;
      @(negedge clk);
      finish_cycle();
      @(posedge clk);
      #1;
   endtask

   task automatic reset_checks();
      check_val("rst_an_n", an_n, 4'hF);
      check_val("rst_dec", dec_nibble, 4'h0);
      check_val("rst_tick", frame_tick, 1'b0);
      check_val("rst_ready", load_ready, 1'b1);
   endtask

   initial begin
      int n;
      rst_n = 1'b0; enable = 1'b1; load_valid = 1'b0; value_in = '0; blank_mask = '0;
      model_reset();
      repeat (3) @(posedge clk);
      #1;
      reset_checks();
      rst_n = 1'b1;

      // Basic scan with a load at cycle 2
      for (int i = 0; i < 3*FRM; i++) step(t == 2, 16'h1234, 1, 4'h0);

      // Mid-frame load followed by offers while not ready
      n = 0;
      while (!((t % FRM) == 6 && !m_pend) && n < 100) begin step(0, 0, 1, 0); n++; end
      check_val("wait_mid", n < 100, 1);
      step(1, 16'hABCD, 1, 0);
      for (int i = 0; i < 6; i++) step(1, 16'h5555, 1, 0);
      for (int i = 0; i < 2*FRM; i++) step(0, 0, 1, 0);

      // Load in the frame-end cycle itself
      n = 0;
      while (!((t % FRM) == FRM-1 && !m_pend) && n < 100) begin step(0, 0, 1, 0); n++; end
      check_val("wait_edge", n < 100, 1);
      step(1, 16'h9876, 1, 0);
      for (int i = 0; i < 2*FRM + 5; i++) step(0, 0, 1, 0);

      // Blanking and enable low
      for (int i = 0; i < 10; i++) step(0, 0, 1, 4'b0101);
      for (int i = 0; i < 30; i++) step(0, 0, 0, 4'b0101);
      for (int i = 0; i < FRM; i++) step(0, 0, 1, 4'b0101);

      // Random traffic
      for (int i = 0; i < 200; i++)
         step($urandom_range(0, 3) == 0, 16'($urandom), $urandom_range(0, 7) != 0, 4'($urandom));

      // Asynchronous reset in the middle of digit 2 drive with a pending load
      n = 0;
      while (!((t % FRM) == 2*SLOT + 2 && m_pend) && n < 100) begin step(1, 16'h4321, 1, 0); n++; end
      check_val("wait_rst", n < 100, 1);
      check_val("pre_rst_an_n", an_n, 4'b1011);
      #1 rst_n = 1'b0;
      #1;
      reset_checks();
      @(posedge clk);
      @(posedge clk);
      #1;
      reset_checks();
      model_reset();
      rst_n = 1'b1;
      for (int i = 0; i < 3*FRM; i++) step(t == 3, 16'hC0DE, 1, 0);

      $display("%0d/%0d checks passed", passed, total);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL timeout t=%0d", t);
      $fatal(1, "timeout");
   end

endmodule
